// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_MATCH   = 2'b10,
        ST_SAT     = 2'b11
    } status_t;

endpackage

// File: rtl/seq_det_prefix_cmp.sv
// Combinational comparator: full-pattern match flag and the longest history
// suffix that equals a pattern prefix (bounded by the fill level).
module seq_det_prefix_cmp #(
    parameter int W       = 1,
    parameter int PAT_LEN = 4,
    parameter int FILL_W  = $clog2(PAT_LEN + 1),
    parameter int PROG_W  = $clog2(PAT_LEN)
) (
    input  logic [PAT_LEN*W-1:0] hist,
    input  logic [PAT_LEN*W-1:0] pat,
    input  logic [FILL_W-1:0]    fill,
    output logic                 full,
    output logic [PROG_W-1:0]    pfx
);

    logic ok;

    always_comb begin
        full = (hist == pat) && (fill == FILL_W'(PAT_LEN));
        pfx  = '0;
        ok   = 1'b0;
        // Ascending k, so the last hit is the longest prefix.
        for (int unsigned kk = 1; kk < PAT_LEN; kk++) begin
            ok = (fill >= FILL_W'(kk));
            for (int unsigned j = 0; j < kk; j++) begin
                if (hist[W*(PAT_LEN-kk+j) +: W] != pat[W*j +: W]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                pfx = PROG_W'(kk);
            end
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// saturating match counter and registered status code.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int W       = 1,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_load,
    input  logic [PAT_LEN*W-1:0]       pattern_in,
    input  logic                       overlap,
    input  logic                       in_valid,
    input  logic [W-1:0]               x,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_LEN)-1:0] prog,
    output logic [1:0]                 y
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int PROG_W = $clog2(PAT_LEN);

    logic [PAT_LEN*W-1:0] pat_q, pat_d;
    logic [PAT_LEN*W-1:0] hist_q, hist_d, hist_sh;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_inc;
    logic [PROG_W-1:0]    prog_q, prog_d, pfx;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 match_q, match_d, full;
    status_t              y_q, y_d;

    // hist[0] (low bits) is the oldest symbol; the new beat enters at the top.
    assign hist_sh  = {x, hist_q[PAT_LEN*W-1:W]};
    assign fill_inc = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);

    seq_det_prefix_cmp #(
        .W       (W),
        .PAT_LEN (PAT_LEN),
        .FILL_W  (FILL_W),
        .PROG_W  (PROG_W)
    ) u_cmp (
        .hist (hist_sh),
        .pat  (pat_q),
        .fill (fill_inc),
        .full (full),
        .pfx  (pfx)
    );

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        if (cfg_load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
            prog_d = '0;
            cnt_d  = '0;
        end else begin
            if (in_valid) begin
                hist_d  = hist_sh;
                fill_d  = fill_inc;
                prog_d  = pfx;
                match_d = full;
                if (full && !overlap) begin
                    fill_d = '0;
                    prog_d = '0;
                end
            end
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (match_d && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (match_d) begin
            y_d = ST_MATCH;
        end else if (cnt_d == '1) begin
            y_d = ST_SAT;
        end else if (prog_d != '0) begin
            y_d = ST_PARTIAL;
        end else begin
            y_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            prog_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            y_q     <= ST_IDLE;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            y_q     <= y_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign prog      = prog_q;
    assign y         = y_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised + directed bench for seq_pattern_detector against a queue-based model.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_load, overlap, in_valid, cnt_clr, x;
    logic [3:0]  pattern_in;
    logic        match_a, match_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b, prog_a, prog_b, y_a, y_b;

    logic        cfg_load_c, overlap_c, in_valid_c, cnt_clr_c;
    logic [11:0] pattern_c;
    logic [3:0]  x_c;
    logic        match_c;
    logic [7:0]  cnt_c;
    logic [1:0]  prog_c, y_c;

    seq_pattern_detector #(.W(1), .PAT_LEN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern_in(pattern_in),
        .overlap(overlap), .in_valid(in_valid), .x(x), .cnt_clr(cnt_clr),
        .match(match_a), .match_cnt(cnt_a), .prog(prog_a), .y(y_a));

    seq_pattern_detector #(.W(1), .PAT_LEN(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern_in(pattern_in),
        .overlap(overlap), .in_valid(in_valid), .x(x), .cnt_clr(cnt_clr),
        .match(match_b), .match_cnt(cnt_b), .prog(prog_b), .y(y_b));

    seq_pattern_detector #(.W(4), .PAT_LEN(3), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .cfg_load(cfg_load_c), .pattern_in(pattern_c),
        .overlap(overlap_c), .in_valid(in_valid_c), .x(x_c), .cnt_clr(cnt_clr_c),
        .match(match_c), .match_cnt(cnt_c), .prog(prog_c), .y(y_c));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: accepted beats since the last restart (at most PAT_LEN kept) and the pattern.
    int  qa[$], pa[$], qc[$], pc[$];
    bit  em_a, em_c;
    int  ecnt_a, ecnt_b, ecnt_c, eprog_a, eprog_c;

    function automatic bit full_match(int q[$], int p[$], int n);
        if (q.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) if (q[i] != p[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Longest k < n such that the last k beats spell the first k pattern symbols.
    function automatic int prefix(int q[$], int p[$], int n);
        int best = 0;
        for (int k = 1; k < n; k++) begin
            if (k <= q.size()) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++) if (q[q.size()-k+j] != p[j]) ok = 1'b0;
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic int next_cnt(int c, bit m, bit clr, int cmax);
        if (clr) return 0;
        if (m && c < cmax) return c + 1;
        return c;
    endfunction

    function automatic int exp_y(bit m, int c, int cmax, int pr);
        if (m) return 2;
        if (c == cmax) return 3;
        if (pr > 0) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        pa = {0, 0, 0, 0};
        pc = {0, 0, 0};
        qa.delete(); qc.delete();
        em_a = 0; em_c = 0;
        ecnt_a = 0; ecnt_b = 0; ecnt_c = 0; eprog_a = 0; eprog_c = 0;
    endtask

    task automatic step_ab();
        em_a = 0;
        if (cfg_load) begin
            pa.delete();
            for (int i = 0; i < 4; i++) pa.push_back(int'(pattern_in[i]));
            qa.delete();
            eprog_a = 0; ecnt_a = 0; ecnt_b = 0;
        end else begin
            if (in_valid) begin
                qa.push_back(int'(x));
                if (qa.size() > 4) void'(qa.pop_front());
                em_a = full_match(qa, pa, 4);
                if (em_a && !overlap) qa.delete();
                eprog_a = prefix(qa, pa, 4);
            end
            ecnt_a = next_cnt(ecnt_a, em_a, cnt_clr, 255);
            ecnt_b = next_cnt(ecnt_b, em_a, cnt_clr, 3);
        end
    endtask

    task automatic step_c();
        em_c = 0;
        if (cfg_load_c) begin
            pc.delete();
            for (int i = 0; i < 3; i++) pc.push_back(int'(pattern_c[4*i +: 4]));
            qc.delete();
            eprog_c = 0; ecnt_c = 0;
        end else begin
            if (in_valid_c) begin
                qc.push_back(int'(x_c));
                if (qc.size() > 3) void'(qc.pop_front());
                em_c = full_match(qc, pc, 3);
                if (em_c && !overlap_c) qc.delete();
                eprog_c = prefix(qc, pc, 3);
            end
            ecnt_c = next_cnt(ecnt_c, em_c, cnt_clr_c, 255);
        end
    endtask

    task automatic compare_all();
        check("a_match", match_a, em_a);
        check("a_cnt",   cnt_a,   ecnt_a);
        check("a_prog",  prog_a,  eprog_a);
        check("a_y",     y_a,     exp_y(em_a, ecnt_a, 255, eprog_a));
        check("b_match", match_b, em_a);
        check("b_cnt",   cnt_b,   ecnt_b);
        check("b_prog",  prog_b,  eprog_a);
        check("b_y",     y_b,     exp_y(em_a, ecnt_b, 3, eprog_a));
        check("c_match", match_c, em_c);
        check("c_cnt",   cnt_c,   ecnt_c);
        check("c_prog",  prog_c,  eprog_c);
        check("c_y",     y_c,     exp_y(em_c, ecnt_c, 255, eprog_c));
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        step_ab();
        step_c();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        cfg_load = 0; in_valid = 0; cnt_clr = 0; x = 0;
        cfg_load_c = 0; in_valid_c = 0; cnt_clr_c = 0; x_c = '0;
    endtask

    task automatic load_a(input logic [3:0] p);
        idle_inputs();
        cfg_load = 1; pattern_in = p;
        cycle();
        cfg_load = 0;
    endtask

    task automatic beat_a(input bit v, input bit b);
        in_valid = v; x = b;
        cycle();
        in_valid = 0;
    endtask

    bit s7 [7] = '{1, 0, 1, 1, 0, 1, 1};

    initial begin
        rst = 0; overlap = 1; overlap_c = 1;
        pattern_in = 4'b1101; pattern_c = 12'hF5A;
        idle_inputs();
        #3;
        model_reset();
        compare_all();
        #4 rst = 1;

        // Overlapping detection of 1,0,1,1 in 1,0,1,1,0,1,1.
        overlap = 1;
        load_a(4'b1101);
        for (int i = 0; i < 7; i++) begin
            beat_a(1, s7[i]);
            if (i < 3) check("t2_prog", prog_a, i + 1);
            if (i == 3 || i == 6) check("t2_match", match_a, 1);
        end
        check("t2_cnt", cnt_a, 2);

        // Same stream without overlap: only the first match counts.
        overlap = 0;
        load_a(4'b1101);
        for (int i = 0; i < 7; i++) begin
            beat_a(1, s7[i]);
            if (i == 6) check("t3_match7", match_a, 0);
        end
        check("t3_cnt", cnt_a, 1);

        // Async reset between edges with live state; pattern becomes 0000.
        overlap = 1;
        load_a(4'b1101);
        beat_a(1, 1); beat_a(1, 0); beat_a(1, 1);
        #2 rst = 0;
        #1;
        model_reset();
        check("t1_prog_async", prog_a, 0);
        compare_all();
        #2 rst = 1;
        for (int i = 0; i < 4; i++) begin
            beat_a(1, 0);
            check("t1_fresh", match_a, (i == 3) ? 1 : 0);
        end

        // Gaps between pattern beats.
        load_a(4'b1101);
        beat_a(1, 1); beat_a(0, 0); beat_a(0, 1); beat_a(1, 0);
        beat_a(0, 1); beat_a(1, 1); beat_a(0, 0); beat_a(1, 1);
        check("t4_match", match_a, 1);
        beat_a(0, 1);
        check("t4_pulse_end", match_a, 0);

        // Five overlapped matches saturate the 2-bit counter; then clear on a match.
        load_a(4'b1101);
        for (int i = 0; i < 16; i++) begin
            beat_a(1, (i == 0) ? 1'b1 : ((i % 3 == 1) ? 1'b0 : 1'b1));
            if (i == 14) check("t5_y_between", y_b, 3);
            if (i == 15) check("t5_y_pulse", y_b, 2);
        end
        check("t5_cnt_sat", cnt_b, 3);
        check("t5_cnt_wide", cnt_a, 5);
        beat_a(1, 0); beat_a(1, 1);
        cnt_clr = 1;
        beat_a(1, 1);
        cnt_clr = 0;
        check("t5_clr_match", match_b, 1);
        check("t5_clr_cnt", cnt_b, 0);

        // cfg_load on the completing beat wins; new pattern 0,1,1,0 active next beat.
        load_a(4'b1101);
        beat_a(1, 1); beat_a(1, 0); beat_a(1, 1);
        cfg_load = 1; pattern_in = 4'b0110; in_valid = 1; x = 1;
        cycle();
        cfg_load = 0; in_valid = 0;
        check("t6_no_match", match_a, 0);
        check("t6_cnt", cnt_a, 0);
        beat_a(1, 0); beat_a(1, 1); beat_a(1, 1); beat_a(1, 0);
        check("t6_new_pat", match_a, 1);

        // Wide symbols: pattern A,5,F matched by 0,A,5,F.
        idle_inputs();
        cfg_load_c = 1; pattern_c = 12'hF5A;
        cycle();
        cfg_load_c = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid_c = 1;
            x_c = (i == 0) ? 4'h0 : pattern_c[4*(i-1) +: 4];
            cycle();
            check("t6c_match", match_c, (i == 3) ? 1 : 0);
        end
        in_valid_c = 0;

        // Random traffic on all instances.
        for (int n = 0; n < 3000; n++) begin
            cfg_load   = ($urandom_range(63) == 0);
            if (cfg_load) pattern_in = 4'($urandom);
            if ($urandom_range(15) == 0) overlap = ~overlap;
            in_valid   = ($urandom_range(3) != 0);
            x          = 1'($urandom);
            cnt_clr    = ($urandom_range(31) == 0);
            cfg_load_c = ($urandom_range(127) == 0);
            if (cfg_load_c) pattern_c = 12'($urandom);
            if ($urandom_range(15) == 0) overlap_c = ~overlap_c;
            in_valid_c = ($urandom_range(3) != 0);
            x_c        = ($urandom_range(4) == 0) ? 4'($urandom)
                                                  : pattern_c[4*$urandom_range(2) +: 4];
            cnt_clr_c  = ($urandom_range(63) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
